// File: rtl/ddr_pmon_mc_seq_pkg.sv
// Shared state type, timing constants and channel-search helper for the
// multi-channel PMON sequencer.
package ddr_pmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_INIT,
        ST_MEAS,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } pmon_state_t;

    localparam int SETTLE_CYC = 4;
    localparam int INIT_MIN   = 6;
    localparam int MAX_CH     = 16;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Lowest enabled channel index at or above ptr, or -1 when none remain.
    function automatic int lowest_en_ch(input logic [MAX_CH-1:0] mask, input int ptr);
        int pick;
        pick = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= ptr)) begin
                pick = i;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ddr_pmon_mc_seq_if.sv
// CSR-side control/result bundle of the PMON sequencer.
// Threshold alarm signals exist only when DDR_PMON_THRESH_EN is defined.
interface ddr_pmon_mc_seq_if
    import ddr_pmon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int REF_W  = 12,
    parameter int INIT_W = 8
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0]       i_ch_en;
    logic                    i_start;
    logic                    i_continuous;
    logic [INIT_W-1:0]       i_initwait;
    logic [REF_W-1:0]        i_refcount;
    logic                    o_busy;
    logic                    o_done;
    logic [CH_W-1:0]         o_ch_sel;
    logic [NUM_CH-1:0]       o_ch_valid;
    logic [NUM_CH*CNT_W-1:0] o_count;

`ifdef DDR_PMON_THRESH_EN
    logic [CNT_W-1:0]        i_thr_lo;
    logic [CNT_W-1:0]        i_thr_hi;
    logic [NUM_CH-1:0]       o_alarm;

    modport master (
        output i_ch_en, i_start, i_continuous, i_initwait, i_refcount, i_thr_lo, i_thr_hi,
        input  o_busy, o_done, o_ch_sel, o_ch_valid, o_count, o_alarm
    );
    modport slave (
        input  i_ch_en, i_start, i_continuous, i_initwait, i_refcount, i_thr_lo, i_thr_hi,
        output o_busy, o_done, o_ch_sel, o_ch_valid, o_count, o_alarm
    );
`else
    modport master (
        output i_ch_en, i_start, i_continuous, i_initwait, i_refcount,
        input  o_busy, o_done, o_ch_sel, o_ch_valid, o_count
    );
    modport slave (
        input  i_ch_en, i_start, i_continuous, i_initwait, i_refcount,
        output o_busy, o_done, o_ch_sel, o_ch_valid, o_count
    );
`endif

endinterface

// File: rtl/ddr_pmon_mc_seq_osc_cnt.sv
// Per-channel ring-oscillator edge counter; clear and gate arrive from the
// refclk domain and are resynchronized before use.
module ddr_pmon_osc_cnt #(
    parameter int CNT_W = 24
) (
    input  logic             i_osc_clk,
    input  logic             refclk_rst_sync,
    input  logic             i_clr,
    input  logic             i_gate,
    output logic [CNT_W-1:0] o_cnt
);

    logic [1:0]       clr_demet_q, clr_demet_d;
    logic [1:0]       gate_demet_q, gate_demet_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_osc_clk or posedge refclk_rst_sync) begin : ddr_demet_r
        if (refclk_rst_sync) begin
            clr_demet_q  <= '0;
            gate_demet_q <= '0;
            cnt_q        <= '0;
        end else begin
            clr_demet_q  <= clr_demet_d;
            gate_demet_q <= gate_demet_d;
            cnt_q        <= cnt_d;
        end
    end

    // Counter holds at all-ones rather than wrapping.
    always_comb begin
        clr_demet_d  = {clr_demet_q[0], i_clr};
        gate_demet_d = {gate_demet_q[0], i_gate};
        cnt_d        = cnt_q;
        if (clr_demet_q[1]) begin
            cnt_d = '0;
        end else if (gate_demet_q[1] && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/ddr_pmon_mc_seq.sv
// Multi-channel PMON sequencer: sweeps enabled oscillators one at a time.
// Define DDR_PMON_THRESH_EN to add the per-channel threshold alarm.
module ddr_pmon_mc_seq
    import ddr_pmon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int REF_W  = 12,
    parameter int INIT_W = 8
) (
    input  logic              refclk_sync,
    input  logic              refclk_rst_sync,
    input  logic [NUM_CH-1:0] i_osc_clk,
    output logic [NUM_CH-1:0] o_ana_en,
    ddr_pmon_mc_seq_if.slave  csr
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int TMR_W = (REF_W > INIT_W) ? REF_W : INIT_W;

    pmon_state_t             state_q, state_d;
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [NUM_CH-1:0]       clr_q, clr_d;
    logic [NUM_CH-1:0]       gate_q, gate_d;
    logic [NUM_CH-1:0]       valid_q, valid_d;
    logic [NUM_CH*CNT_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0]       ana_en;
    logic [TMR_W-1:0]        init_len;
    logic [TMR_W-1:0]        ref_len;
    logic [MAX_CH-1:0]       en_mask;
    logic [CNT_W-1:0]        osc_cnt [NUM_CH];
`ifdef DDR_PMON_THRESH_EN
    logic [NUM_CH-1:0]       alarm_q, alarm_d;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_osc
        ddr_pmon_osc_cnt #(.CNT_W(CNT_W)) u_osc_cnt (
            .i_osc_clk       (i_osc_clk[g]),
            .refclk_rst_sync (refclk_rst_sync),
            .i_clr           (clr_q[g]),
            .i_gate          (gate_q[g]),
            .o_cnt           (osc_cnt[g])
        );
    end

    // Short init waits and an empty window are clamped to usable minimums.
    assign init_len = (csr.i_initwait < INIT_W'(INIT_MIN)) ? TMR_W'(INIT_MIN) : TMR_W'(csr.i_initwait);
    assign ref_len  = (csr.i_refcount == '0) ? TMR_W'(1) : TMR_W'(csr.i_refcount);
    assign en_mask  = MAX_CH'(csr.i_ch_en);

    always_ff @(posedge refclk_sync or posedge refclk_rst_sync) begin
        if (refclk_rst_sync) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            timer_q <= '0;
            clr_q   <= '0;
            gate_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
`ifdef DDR_PMON_THRESH_EN
            alarm_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            clr_q   <= clr_d;
            gate_q  <= gate_d;
            valid_q <= valid_d;
            count_q <= count_d;
`ifdef DDR_PMON_THRESH_EN
            alarm_q <= alarm_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (csr.i_start) begin
                    state_d = ST_SELECT;
                    ptr_d   = '0;
                end
            end
            ST_SELECT: begin
                if (lowest_en_ch(en_mask, int'(ptr_q)) >= 0) begin
                    ch_d    = CH_W'(lowest_en_ch(en_mask, int'(ptr_q)));
                    timer_d = init_len - TMR_W'(1);
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_INIT: begin
                if (timer_q == '0) begin
                    timer_d = ref_len - TMR_W'(1);
                    state_d = ST_MEAS;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_MEAS: begin
                if (timer_q == '0) begin
                    timer_d = TMR_W'(SETTLE_CYC - 1);
                    state_d = ST_SETTLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d   = ch_q + CH_W'(1);
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                if (csr.i_continuous) begin
                    ptr_d   = '0;
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear/gate are registered from the next state so the osc domain sees glitch-free levels.
    always_comb begin
        ana_en  = '0;
        clr_d   = '0;
        gate_d  = '0;
        valid_d = valid_q;
        count_d = count_q;
`ifdef DDR_PMON_THRESH_EN
        alarm_d = alarm_q;
`endif
        if ((state_q == ST_IDLE) && csr.i_start) begin
            valid_d = '0;
`ifdef DDR_PMON_THRESH_EN
            alarm_d = '0;
`endif
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                ana_en[i] = (state_q == ST_INIT) || (state_q == ST_MEAS) || (state_q == ST_SETTLE);
                if (state_q == ST_CAPTURE) begin
                    count_d[i*CNT_W +: CNT_W] = osc_cnt[i];
                    valid_d[i]                = 1'b1;
`ifdef DDR_PMON_THRESH_EN
                    if ((osc_cnt[i] < csr.i_thr_lo) || (osc_cnt[i] > csr.i_thr_hi)) begin
                        alarm_d[i] = 1'b1;
                    end
`endif
                end
            end
            clr_d[i]  = (state_d == ST_INIT) && (ch_d == CH_W'(i));
            gate_d[i] = (state_d == ST_MEAS) && (ch_d == CH_W'(i));
        end
    end

    assign o_ana_en       = ana_en;
    assign csr.o_busy     = (state_q != ST_IDLE);
    assign csr.o_done     = (state_q == ST_DONE);
    assign csr.o_ch_sel   = ch_q;
    assign csr.o_ch_valid = valid_q;
    assign csr.o_count    = count_q;
`ifdef DDR_PMON_THRESH_EN
    assign csr.o_alarm    = alarm_q;
`endif

endmodule

// File: tb/tb_ddr_pmon_mc_seq.sv
// Directed bench for ddr_pmon_mc_seq; exercises DDR_PMON_THRESH_EN when defined.
module tb_ddr_pmon_mc_seq;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 24;
    localparam int REF_W  = 12;
    localparam int INIT_W = 8;

    logic refclk_sync     = 1'b0;
    logic refclk_rst_sync = 1'b1;
    logic osc0 = 1'b0, osc1 = 1'b0, osc2 = 1'b0, osc3 = 1'b0, osc_sat = 1'b0;
    logic [NUM_CH-1:0] ana_en;
    logic [0:0]        ana_en_sat;
    int checks = 0;
    int errors = 0;

    ddr_pmon_mc_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REF_W(REF_W), .INIT_W(INIT_W)) csr_if ();
    ddr_pmon_mc_seq_if #(.NUM_CH(1), .CNT_W(8), .REF_W(REF_W), .INIT_W(INIT_W)) sat_if ();

    ddr_pmon_mc_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REF_W(REF_W), .INIT_W(INIT_W)) u_dut (
        .refclk_sync     (refclk_sync),
        .refclk_rst_sync (refclk_rst_sync),
        .i_osc_clk       ({osc3, osc2, osc1, osc0}),
        .o_ana_en        (ana_en),
        .csr             (csr_if)
    );

    ddr_pmon_mc_seq #(.NUM_CH(1), .CNT_W(8), .REF_W(REF_W), .INIT_W(INIT_W)) u_sat (
        .refclk_sync     (refclk_sync),
        .refclk_rst_sync (refclk_rst_sync),
        .i_osc_clk       (osc_sat),
        .o_ana_en        (ana_en_sat),
        .csr             (sat_if)
    );

    // refclk period 240; oscillators at 2x, 3x, 4x, 5x and 1/10 of refclk, offset so edges never coincide
    always #120 refclk_sync = ~refclk_sync;
    initial begin #7; forever #60 osc0 = ~osc0; end
    initial begin #7; forever #40 osc1 = ~osc1; end
    initial begin #7; forever #30 osc2 = ~osc2; end
    initial begin #7; forever #24 osc3 = ~osc3; end
    initial begin #7; forever #1200 osc_sat = ~osc_sat; end

    initial begin
        #30000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_sweep();
        @(negedge refclk_sync);
        csr_if.i_start = 1'b1;
        @(negedge refclk_sync);
        csr_if.i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge refclk_sync);
        checks++; if (csr_if.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", csr_if.o_busy); end
        checks++; if (csr_if.o_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", csr_if.o_done); end
        checks++; if (csr_if.o_ch_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch_sel: got %0d expected 0", csr_if.o_ch_sel); end
        checks++; if (csr_if.o_ch_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0000", csr_if.o_ch_valid); end
        checks++; if (csr_if.o_count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0", csr_if.o_count); end
        checks++; if (ana_en !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ana_en: got %b expected 0000", ana_en); end
        checks++; if (sat_if.o_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_sat_count: got %0d expected 0", sat_if.o_count); end
        refclk_rst_sync = 1'b0;
        @(negedge refclk_sync);
        checks++; if (csr_if.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %0b expected 0", csr_if.o_busy); end
    endtask

    task automatic test_sparse_mask();
        int cyc;
        int got;
        csr_if.i_ch_en      = 4'b0101;
        csr_if.i_initwait   = 8'd6;
        csr_if.i_refcount   = 12'd20;
        csr_if.i_continuous = 1'b0;
        start_sweep();
        cyc = 1;
        while (csr_if.o_done !== 1'b1 && cyc < 200) begin @(negedge refclk_sync); cyc++; end
        checks++; if (cyc != 66) begin errors++; $display("[TB] FAIL sparse_done_cycle: got %0d expected 66", cyc); end
        checks++; if (csr_if.o_ch_valid !== 4'b0101) begin errors++; $display("[TB] FAIL sparse_valid: got %b expected 0101", csr_if.o_ch_valid); end
        got = int'(csr_if.o_count[0*CNT_W +: CNT_W]);
        checks++; if (got < 38 || got > 42) begin errors++; $display("[TB] FAIL sparse_ch0_count: got %0d expected 40+-2", got); end
        got = int'(csr_if.o_count[2*CNT_W +: CNT_W]);
        checks++; if (got < 78 || got > 82) begin errors++; $display("[TB] FAIL sparse_ch2_count: got %0d expected 80+-2", got); end
        checks++; if (csr_if.o_count[1*CNT_W +: CNT_W] !== 24'd0) begin errors++; $display("[TB] FAIL sparse_ch1_count: got %0d expected 0", csr_if.o_count[1*CNT_W +: CNT_W]); end
        checks++; if (csr_if.o_count[3*CNT_W +: CNT_W] !== 24'd0) begin errors++; $display("[TB] FAIL sparse_ch3_count: got %0d expected 0", csr_if.o_count[3*CNT_W +: CNT_W]); end
        @(negedge refclk_sync);
        checks++; if (csr_if.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL sparse_idle_busy: got %0b expected 0", csr_if.o_busy); end
    endtask

    task automatic test_basic_capture();
        int cyc;
        int got;
        int exp_cnt [4] = '{200, 300, 400, 500};
        csr_if.i_ch_en    = 4'b1111;
        csr_if.i_initwait = 8'd8;
        csr_if.i_refcount = 12'd100;
`ifdef DDR_PMON_THRESH_EN
        csr_if.i_thr_lo = 24'd250;
        csr_if.i_thr_hi = 24'd450;
`endif
        start_sweep();
        cyc = 1;
        checks++; if (csr_if.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %0b expected 1", csr_if.o_busy); end
        while (csr_if.o_done !== 1'b1 && cyc < 600) begin
            if (cyc == 2) begin
                checks++; if (ana_en !== 4'b0001) begin errors++; $display("[TB] FAIL basic_ana_en_ch0: got %b expected 0001", ana_en); end
            end
            if (cyc == 116) begin
                checks++; if (ana_en !== 4'b0010) begin errors++; $display("[TB] FAIL basic_ana_en_ch1: got %b expected 0010", ana_en); end
                checks++; if (csr_if.o_ch_sel !== 2'd1) begin errors++; $display("[TB] FAIL basic_ch_sel: got %0d expected 1", csr_if.o_ch_sel); end
            end
            @(negedge refclk_sync);
            cyc++;
        end
        checks++; if (cyc != 457) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 457", cyc); end
        checks++; if (csr_if.o_ch_valid !== 4'b1111) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1111", csr_if.o_ch_valid); end
        for (int i = 0; i < 4; i++) begin
            got = int'(csr_if.o_count[i*CNT_W +: CNT_W]);
            checks++;
            if (got < exp_cnt[i] - 2 || got > exp_cnt[i] + 2) begin
                errors++; $display("[TB] FAIL basic_ch%0d_count: got %0d expected %0d+-2", i, got, exp_cnt[i]);
            end
        end
`ifdef DDR_PMON_THRESH_EN
        checks++; if (csr_if.o_alarm !== 4'b1001) begin errors++; $display("[TB] FAIL thresh_alarm: got %b expected 1001", csr_if.o_alarm); end
`endif
        @(negedge refclk_sync);
        checks++; if (csr_if.o_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %0b expected 0", csr_if.o_done); end
        checks++; if (csr_if.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy: got %0b expected 0", csr_if.o_busy); end
    endtask

    task automatic test_empty_mask();
        int cyc;
        int got;
        csr_if.i_ch_en = 4'b0000;
        start_sweep();
        cyc = 1;
        while (csr_if.o_done !== 1'b1 && cyc < 20) begin @(negedge refclk_sync); cyc++; end
        checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL empty_done_cycle: got %0d expected 2", cyc); end
        checks++; if (csr_if.o_ch_valid !== 4'b0000) begin errors++; $display("[TB] FAIL empty_valid: got %b expected 0000", csr_if.o_ch_valid); end
        got = int'(csr_if.o_count[3*CNT_W +: CNT_W]);
        checks++; if (got < 498 || got > 502) begin errors++; $display("[TB] FAIL empty_ch3_kept: got %0d expected 500+-2", got); end
`ifdef DDR_PMON_THRESH_EN
        checks++; if (csr_if.o_alarm !== 4'b0000) begin errors++; $display("[TB] FAIL thresh_alarm_clear: got %b expected 0000", csr_if.o_alarm); end
`endif
        @(negedge refclk_sync);
    endtask

    task automatic test_clamps();
        int cyc;
        int en_cyc;
        int got;
        csr_if.i_ch_en    = 4'b0001;
        csr_if.i_initwait = 8'd2;
        csr_if.i_refcount = 12'd0;
        start_sweep();
        cyc    = 1;
        en_cyc = 0;
        while (csr_if.o_done !== 1'b1 && cyc < 100) begin
            if (ana_en != 4'b0000) en_cyc++;
            @(negedge refclk_sync);
            cyc++;
        end
        checks++; if (cyc != 15) begin errors++; $display("[TB] FAIL clamp_done_cycle: got %0d expected 15", cyc); end
        checks++; if (en_cyc != 11) begin errors++; $display("[TB] FAIL clamp_ana_en_cycles: got %0d expected 11", en_cyc); end
        got = int'(csr_if.o_count[0*CNT_W +: CNT_W]);
        checks++; if (got > 4) begin errors++; $display("[TB] FAIL clamp_ch0_count: got %0d expected 0..4", got); end
        got = int'(csr_if.o_count[1*CNT_W +: CNT_W]);
        checks++; if (got < 298 || got > 302) begin errors++; $display("[TB] FAIL clamp_ch1_hold: got %0d expected 300+-2", got); end
        @(negedge refclk_sync);
    endtask

    task automatic test_continuous();
        int cyc;
        int ndone;
        int done_at [4] = '{0, 0, 0, 0};
        logic busy16;
        logic busy46;
        busy16 = 1'b0;
        busy46 = 1'b1;
        csr_if.i_ch_en      = 4'b0001;
        csr_if.i_initwait   = 8'd6;
        csr_if.i_refcount   = 12'd1;
        csr_if.i_continuous = 1'b1;
        start_sweep();
        cyc   = 1;
        ndone = 0;
        while (cyc < 50) begin
            if (csr_if.o_done === 1'b1) begin
                if (ndone < 4) done_at[ndone] = cyc;
                ndone++;
            end
            if (cyc == 16) busy16 = csr_if.o_busy;
            if (cyc == 46) busy46 = csr_if.o_busy;
            csr_if.i_start = (cyc == 20);
            if (cyc == 35) csr_if.i_continuous = 1'b0;
            @(negedge refclk_sync);
            cyc++;
        end
        csr_if.i_start = 1'b0;
        checks++; if (ndone != 3) begin errors++; $display("[TB] FAIL cont_done_count: got %0d expected 3", ndone); end
        checks++; if (done_at[0] != 15) begin errors++; $display("[TB] FAIL cont_done0: got %0d expected 15", done_at[0]); end
        checks++; if (done_at[1] != 30) begin errors++; $display("[TB] FAIL cont_done1: got %0d expected 30", done_at[1]); end
        checks++; if (done_at[2] != 45) begin errors++; $display("[TB] FAIL cont_done2: got %0d expected 45", done_at[2]); end
        checks++; if (busy16 !== 1'b1) begin errors++; $display("[TB] FAIL cont_busy_between: got %0b expected 1", busy16); end
        checks++; if (busy46 !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy_after_drop: got %0b expected 0", busy46); end
    endtask

    task automatic test_reset_mid_meas();
        int cyc;
        csr_if.i_ch_en    = 4'b1111;
        csr_if.i_initwait = 8'd6;
        csr_if.i_refcount = 12'd50;
        start_sweep();
        cyc = 1;
        while (cyc < 90) begin @(negedge refclk_sync); cyc++; end
        checks++; if (ana_en !== 4'b0010) begin errors++; $display("[TB] FAIL midrst_pre_ana_en: got %b expected 0010", ana_en); end
        refclk_rst_sync = 1'b1;
        #1;
        checks++; if (csr_if.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", csr_if.o_busy); end
        checks++; if (ana_en !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_ana_en: got %b expected 0000", ana_en); end
        checks++; if (csr_if.o_count !== '0) begin errors++; $display("[TB] FAIL midrst_count: got %h expected 0", csr_if.o_count); end
        checks++; if (csr_if.o_ch_valid !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0000", csr_if.o_ch_valid); end
        checks++; if (csr_if.o_ch_sel !== 2'd0) begin errors++; $display("[TB] FAIL midrst_ch_sel: got %0d expected 0", csr_if.o_ch_sel); end
        @(negedge refclk_sync);
        refclk_rst_sync = 1'b0;
        repeat (3) @(negedge refclk_sync);
        checks++; if (csr_if.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stays_idle: got %0b expected 0", csr_if.o_busy); end
    endtask

    task automatic test_saturation();
        int cyc;
        sat_if.i_ch_en      = 1'b1;
        sat_if.i_initwait   = 8'd30;
        sat_if.i_refcount   = 12'd4095;
        sat_if.i_continuous = 1'b0;
        @(negedge refclk_sync);
        sat_if.i_start = 1'b1;
        @(negedge refclk_sync);
        sat_if.i_start = 1'b0;
        cyc = 1;
        while (sat_if.o_done !== 1'b1 && cyc < 4400) begin @(negedge refclk_sync); cyc++; end
        checks++; if (cyc != 4132) begin errors++; $display("[TB] FAIL sat_done_cycle: got %0d expected 4132", cyc); end
        checks++; if (sat_if.o_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 255", sat_if.o_count); end
        checks++; if (sat_if.o_ch_valid !== 1'b1) begin errors++; $display("[TB] FAIL sat_valid: got %0b expected 1", sat_if.o_ch_valid); end
    endtask

    initial begin
        csr_if.i_ch_en      = '0;
        csr_if.i_start      = 1'b0;
        csr_if.i_continuous = 1'b0;
        csr_if.i_initwait   = '0;
        csr_if.i_refcount   = '0;
        sat_if.i_ch_en      = '0;
        sat_if.i_start      = 1'b0;
        sat_if.i_continuous = 1'b0;
        sat_if.i_initwait   = '0;
        sat_if.i_refcount   = '0;
`ifdef DDR_PMON_THRESH_EN
        csr_if.i_thr_lo = '0;
        csr_if.i_thr_hi = '1;
        sat_if.i_thr_lo = '0;
        sat_if.i_thr_hi = '1;
`endif
        $display("[TB] starting ddr_pmon_mc_seq bench");
        test_reset();
        test_sparse_mask();
        test_basic_capture();
        test_empty_mask();
        test_clamps();
        test_continuous();
        test_reset_mid_meas();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
